kamacore_forwarding_unit: RTL and testbench

- Producer side of the operand-forwarding path. Resolves the ID-stage source operands against in-flight EX/MEM/WB results and returns forwarded data to ID.
- Keeps a scoreboard of outstanding load destinations. Raises a load-use stall until the load data reaches writeback.
- Includes a stall watchdog that flags a hung pipeline.
- Sits beside the ID stage. Consumes the register-file read data that ID fetches (data_original) and drives data_forwarded back.

---
 rtl/kamacore_forwarding_unit_if.sv | 48 ++++
 rtl/kamacore_forwarding_unit.sv | 109 ++++++++++
 tb/tb_kamacore_forwarding_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kamacore_forwarding_unit_if.sv
// Operand-forwarding bus between the ID/pipeline control (master) and the forwarding unit (slave).
interface kamacore_forwarding_unit_if #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] rs1_a;
    logic [REG_ADDR_WIDTH-1:0] rs2_a;
    logic [CPU_WIDTH-1:0]      rs1_data_original;
    logic [CPU_WIDTH-1:0]      rs2_data_original;
    logic [CPU_WIDTH-1:0]      rs1_data_forwarded;
    logic [CPU_WIDTH-1:0]      rs2_data_forwarded;
    logic                      issue_valid;
    logic                      issue_rd_we;
    logic [REG_ADDR_WIDTH-1:0] issue_rd_a;
    logic                      issue_is_load;
    logic                      flush;
    logic                      ex_rd_we;
    logic                      ex_is_load;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_a;
    logic [CPU_WIDTH-1:0]      ex_rd_data;
    logic                      mem_rd_we;
    logic                      mem_is_load;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_a;
    logic [CPU_WIDTH-1:0]      mem_rd_data;
    logic                      wb_rd_we;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_a;
    logic [CPU_WIDTH-1:0]      wb_rd_data;
    logic                      stall;
    logic                      stall_timeout;

    modport master (
        output rs1_a, rs2_a, rs1_data_original, rs2_data_original,
        output issue_valid, issue_rd_we, issue_rd_a, issue_is_load, flush,
        output ex_rd_we, ex_is_load, ex_rd_a, ex_rd_data,
        output mem_rd_we, mem_is_load, mem_rd_a, mem_rd_data,
        output wb_rd_we, wb_rd_a, wb_rd_data,
        input  rs1_data_forwarded, rs2_data_forwarded, stall, stall_timeout
    );

    modport slave (
        input  rs1_a, rs2_a, rs1_data_original, rs2_data_original,
        input  issue_valid, issue_rd_we, issue_rd_a, issue_is_load, flush,
        input  ex_rd_we, ex_is_load, ex_rd_a, ex_rd_data,
        input  mem_rd_we, mem_is_load, mem_rd_a, mem_rd_data,
        input  wb_rd_we, wb_rd_a, wb_rd_data,
        output rs1_data_forwarded, rs2_data_forwarded, stall, stall_timeout
    );
endinterface

// File: rtl/kamacore_forwarding_unit.sv
// Resolves ID source operands against EX/MEM/WB results, tracks outstanding loads
// for load-use stalls, and flags a pipeline stuck in stall.
module kamacore_forwarding_unit #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int STALL_TIMEOUT  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    kamacore_forwarding_unit_if.slave    bus
);
    localparam int          NUM_REGS  = 2 ** REG_ADDR_WIDTH;
    localparam logic [15:0] TIMEOUT_C = 16'(STALL_TIMEOUT);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_next_s;
    logic [15:0]         stall_cnt_r;
    logic [15:0]         stall_cnt_next_s;
    logic                stall_timeout_r;
    logic                stall_s;
    logic                hazard1_s;
    logic                hazard2_s;
    logic                issue_set_s;

    // Youngest in-flight producer wins; loads in EX/MEM have no data yet.
    function automatic logic [CPU_WIDTH-1:0] forward_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs_a,
        input logic [CPU_WIDTH-1:0]      original
    );
        logic [CPU_WIDTH-1:0] result;
        if (rs_a == {REG_ADDR_WIDTH{1'b0}}) begin
            result = {CPU_WIDTH{1'b0}};
        end else if (bus.ex_rd_we && !bus.ex_is_load && (bus.ex_rd_a == rs_a)) begin
            result = bus.ex_rd_data;
        end else if (bus.mem_rd_we && !bus.mem_is_load && (bus.mem_rd_a == rs_a)) begin
            result = bus.mem_rd_data;
        end else if (bus.wb_rd_we && (bus.wb_rd_a == rs_a)) begin
            result = bus.wb_rd_data;
        end else begin
            result = original;
        end
        return result;
    endfunction

    assign bus.rs1_data_forwarded = forward_sel(bus.rs1_a, bus.rs1_data_original);
    assign bus.rs2_data_forwarded = forward_sel(bus.rs2_a, bus.rs2_data_original);

    // A source that is being written back this cycle is satisfied by forwarding.
    always_comb begin
        hazard1_s = (bus.rs1_a != {REG_ADDR_WIDTH{1'b0}}) && pending_r[bus.rs1_a]
                    && !(bus.wb_rd_we && (bus.wb_rd_a == bus.rs1_a));
        hazard2_s = (bus.rs2_a != {REG_ADDR_WIDTH{1'b0}}) && pending_r[bus.rs2_a]
                    && !(bus.wb_rd_we && (bus.wb_rd_a == bus.rs2_a));
        stall_s   = rst && (hazard1_s || hazard2_s);
    end

    assign bus.stall         = stall_s;
    assign bus.stall_timeout = stall_timeout_r;

    // Scoreboard next state: clear on writeback first so a same-index set overrides it.
    always_comb begin
        pending_next_s = pending_r;
        issue_set_s    = bus.issue_valid && bus.issue_rd_we && bus.issue_is_load
                         && (bus.issue_rd_a != {REG_ADDR_WIDTH{1'b0}})
                         && !bus.flush && !stall_s;
        if (bus.wb_rd_we) begin
            pending_next_s[bus.wb_rd_a] = 1'b0;
        end else begin
            pending_next_s = pending_next_s;
        end
        if (issue_set_s) begin
            pending_next_s[bus.issue_rd_a] = 1'b1;
        end else begin
            pending_next_s = pending_next_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Watchdog counter next state, saturating while stalled.
    always_comb begin
        stall_cnt_next_s = 16'd0;
        if (stall_s) begin
            if (stall_cnt_r == 16'hFFFF) begin
                stall_cnt_next_s = stall_cnt_r;
            end else begin
                stall_cnt_next_s = stall_cnt_r + 16'd1;
            end
        end else begin
            stall_cnt_next_s = 16'd0;
        end
    end

    // State registers: scoreboard, watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r       <= {NUM_REGS{1'b0}};
            stall_cnt_r     <= 16'd0;
            stall_timeout_r <= 1'b0;
        end else begin
            pending_r   <= pending_next_s;
            stall_cnt_r <= stall_cnt_next_s;
            if (stall_s && (stall_cnt_next_s == TIMEOUT_C)) begin
                stall_timeout_r <= 1'b1;
            end else begin
                stall_timeout_r <= stall_timeout_r;
            end
        end
    end
endmodule

// File: tb/tb_kamacore_forwarding_unit.sv
// Directed self-checking bench for kamacore_forwarding_unit.
module tb_kamacore_forwarding_unit;
    localparam int CW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    kamacore_forwarding_unit_if #(.CPU_WIDTH(CW), .REG_ADDR_WIDTH(AW)) bus ();

    kamacore_forwarding_unit #(
        .CPU_WIDTH(CW), .REG_ADDR_WIDTH(AW), .STALL_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.rs1_a = 5'd0;             bus.rs2_a = 5'd0;
        bus.rs1_data_original = 32'd0; bus.rs2_data_original = 32'd0;
        bus.issue_valid = 1'b0; bus.issue_rd_we = 1'b0; bus.issue_rd_a = 5'd0;
        bus.issue_is_load = 1'b0; bus.flush = 1'b0;
        bus.ex_rd_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd_a = 5'd0; bus.ex_rd_data = 32'd0;
        bus.mem_rd_we = 1'b0; bus.mem_is_load = 1'b0; bus.mem_rd_a = 5'd0; bus.mem_rd_data = 32'd0;
        bus.wb_rd_we = 1'b0; bus.wb_rd_a = 5'd0; bus.wb_rd_data = 32'd0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic fl);
        bus.issue_valid = 1'b1; bus.issue_rd_we = 1'b1;
        bus.issue_is_load = 1'b1; bus.issue_rd_a = rd; bus.flush = fl;
    endtask

    task automatic drop_issue();
        bus.issue_valid = 1'b0; bus.issue_rd_we = 1'b0;
        bus.issue_is_load = 1'b0; bus.issue_rd_a = 5'd0; bus.flush = 1'b0;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick(); tick();
        bus.rs1_a = 5'd3; bus.rs1_data_original = 32'h55;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %0b expected 0", bus.stall);
        end
        checks++;
        if (bus.stall_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout: got %0b expected 0", bus.stall_timeout);
        end
        checks++;
        if (bus.rs1_data_forwarded !== 32'h55) begin
            errors++; $display("FAIL reset_fwd: got %h expected 00000055", bus.rs1_data_forwarded);
        end
        rst = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_priority();
        idle();
        bus.rs1_a = 5'd5; bus.rs1_data_original = 32'h1111;
        bus.ex_rd_we = 1'b1;  bus.ex_rd_a = 5'd5;  bus.ex_rd_data = 32'hAAAA;
        bus.mem_rd_we = 1'b1; bus.mem_rd_a = 5'd5; bus.mem_rd_data = 32'hBBBB;
        bus.wb_rd_we = 1'b1;  bus.wb_rd_a = 5'd5;  bus.wb_rd_data = 32'hCCCC;
        #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'hAAAA) begin
            errors++; $display("FAIL fwd_ex: got %h expected 0000aaaa", bus.rs1_data_forwarded);
        end
        bus.ex_is_load = 1'b1; #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'hBBBB) begin
            errors++; $display("FAIL fwd_ex_load_skip: got %h expected 0000bbbb", bus.rs1_data_forwarded);
        end
        bus.ex_is_load = 1'b0; bus.ex_rd_we = 1'b0; #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'hBBBB) begin
            errors++; $display("FAIL fwd_mem: got %h expected 0000bbbb", bus.rs1_data_forwarded);
        end
        bus.mem_is_load = 1'b1; #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'hCCCC) begin
            errors++; $display("FAIL fwd_mem_load_skip: got %h expected 0000cccc", bus.rs1_data_forwarded);
        end
        bus.mem_is_load = 1'b0; bus.mem_rd_we = 1'b0; #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'hCCCC) begin
            errors++; $display("FAIL fwd_wb: got %h expected 0000cccc", bus.rs1_data_forwarded);
        end
        bus.wb_rd_a = 5'd6; #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'h1111) begin
            errors++; $display("FAIL fwd_wb_addr_miss: got %h expected 00001111", bus.rs1_data_forwarded);
        end
        bus.wb_rd_a = 5'd5; bus.wb_rd_we = 1'b0; #1;
        checks++;
        if (bus.rs1_data_forwarded !== 32'h1111) begin
            errors++; $display("FAIL fwd_orig: got %h expected 00001111", bus.rs1_data_forwarded);
        end
        // rs2 path: MEM match with EX on a different register
        bus.rs2_a = 5'd9; bus.rs2_data_original = 32'h2222;
        bus.ex_rd_we = 1'b1; bus.ex_rd_a = 5'd8;
        bus.mem_rd_we = 1'b1; bus.mem_rd_a = 5'd9; #1;
        checks++;
        if (bus.rs2_data_forwarded !== 32'hBBBB) begin
            errors++; $display("FAIL fwd_rs2_mem: got %h expected 0000bbbb", bus.rs2_data_forwarded);
        end
        idle();
        tick();
    endtask

    task automatic test_x0();
        idle();
        bus.rs2_a = 5'd0; bus.rs2_data_original = 32'h7777;
        bus.ex_rd_we = 1'b1;  bus.ex_rd_a = 5'd0;  bus.ex_rd_data = 32'hFFFF;
        bus.mem_rd_we = 1'b1; bus.mem_rd_a = 5'd0; bus.mem_rd_data = 32'hFFFF;
        bus.wb_rd_we = 1'b1;  bus.wb_rd_a = 5'd0;  bus.wb_rd_data = 32'hFFFF;
        issue_load(5'd0, 1'b0);
        #1;
        checks++;
        if (bus.rs2_data_forwarded !== 32'd0) begin
            errors++; $display("FAIL x0_fwd: got %h expected 00000000", bus.rs2_data_forwarded);
        end
        tick();
        idle();
        #1;
        chk1("x0_no_stall", bus.stall, 1'b0);
        tick();
    endtask

    task automatic test_load_use();
        idle();
        issue_load(5'd7, 1'b0);
        tick();
        drop_issue();
        bus.rs1_a = 5'd7; bus.rs1_data_original = 32'h9999;
        #1;
        chk1("load_use_stall", bus.stall, 1'b1);
        // an issue attempt while stalled must be ignored
        issue_load(5'd8, 1'b0);
        tick();
        drop_issue();
        chk1("load_use_stall_held", bus.stall, 1'b1);
        bus.wb_rd_we = 1'b1; bus.wb_rd_a = 5'd7; bus.wb_rd_data = 32'h1234;
        #1;
        chk1("load_use_wb_release", bus.stall, 1'b0);
        checks++;
        if (bus.rs1_data_forwarded !== 32'h1234) begin
            errors++; $display("FAIL load_use_wb_data: got %h expected 00001234", bus.rs1_data_forwarded);
        end
        tick();
        bus.wb_rd_we = 1'b0; #1;
        chk1("load_use_cleared", bus.stall, 1'b0);
        bus.rs1_a = 5'd8; #1;
        chk1("issue_during_stall_ignored", bus.stall, 1'b0);
        // rs2 hazard
        bus.rs1_a = 5'd0;
        issue_load(5'd12, 1'b0);
        tick();
        drop_issue();
        bus.rs2_a = 5'd12; #1;
        chk1("rs2_stall", bus.stall, 1'b1);
        bus.wb_rd_we = 1'b1; bus.wb_rd_a = 5'd12;
        tick();
        idle();
        tick();
    endtask

    task automatic test_flush_and_collision();
        idle();
        issue_load(5'd9, 1'b1);
        tick();
        drop_issue();
        bus.rs1_a = 5'd9; #1;
        chk1("flush_no_pending", bus.stall, 1'b0);
        bus.rs1_a = 5'd0;
        issue_load(5'd3, 1'b0);
        bus.wb_rd_we = 1'b1; bus.wb_rd_a = 5'd3;
        tick();
        drop_issue();
        bus.wb_rd_we = 1'b0;
        bus.rs1_a = 5'd3; #1;
        chk1("set_beats_clear", bus.stall, 1'b1);
        bus.wb_rd_we = 1'b1; bus.wb_rd_a = 5'd3;
        tick();
        idle();
        tick();
    endtask

    task automatic test_watchdog();
        idle();
        issue_load(5'd10, 1'b0);
        tick();
        drop_issue();
        bus.rs1_a = 5'd10;
        tick(); tick(); tick();
        chk1("wd_before_timeout", bus.stall_timeout, 1'b0);
        tick();
        chk1("wd_timeout_set", bus.stall_timeout, 1'b1);
        bus.wb_rd_we = 1'b1; bus.wb_rd_a = 5'd10;
        issue_load(5'd11, 1'b0);
        tick();
        idle();
        #1;
        chk1("wd_stall_dropped", bus.stall, 1'b0);
        chk1("wd_sticky", bus.stall_timeout, 1'b1);
        tick();
        chk1("wd_sticky_2", bus.stall_timeout, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1; #1;
        chk1("wd_reset_clears", bus.stall_timeout, 1'b0);
        bus.rs1_a = 5'd11; #1;
        chk1("reset_clears_pending", bus.stall, 1'b0);
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        issue_load(5'd7, 1'b0);
        tick();
        drop_issue();
        bus.rs1_a = 5'd7; #1;
        chk1("mid_pre_stall", bus.stall, 1'b1);
        rst = 1'b0; #1;
        chk1("mid_stall_forced_low", bus.stall, 1'b0);
        tick();
        chk1("mid_stall_low_in_reset", bus.stall, 1'b0);
        rst = 1'b1; #1;
        chk1("mid_after_release", bus.stall, 1'b0);
        idle();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_priority();
        test_x0();
        test_load_use();
        test_flush_and_collision();
        test_watchdog();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
